// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter of the MIPS pipeline.
package mips_pkg;

    // Arbiter sequencing: wait for a request, run the memory access, pulse ready.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    // Which requester owns the memory (also remembered as the last winner).
    typedef enum logic {
        GNT_IF,
        GNT_D
    } arb_grant_t;

    // Largest supported access latency in cycles.
    localparam int ARB_MAX_LATENCY = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the arbiter.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_pipe;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata, stall_pipe
    );

    // Pipeline plus memory view (the environment around the arbiter).
    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata, stall_pipe
    );

endinterface

// File: rtl/mem_port_arbiter_rr2.sv
// Two-way round-robin picker: bit 0 is the fetch port, bit 1 the data port.
module arb_rr2
    import mips_pkg::*;
(
    input  logic [1:0] req,
    input  arb_grant_t last_grant,
    output arb_grant_t grant,
    output logic       valid
);

    // A lone request wins outright; on a tie the port that did not win last time goes.
    always_comb begin
        valid = |req;
        grant = GNT_IF;
        if (req == 2'b11) begin
            grant = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
        end else if (req[1]) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// Each granted request runs LATENCY enable cycles, then one ready cycle.
// LATENCY must lie in 1..ARB_MAX_LATENCY.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    arb_state_t       state_reg;
    // Doubles as the current grant id while a transaction is in flight.
    arb_grant_t       last_grant_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The memory-side registers hold the latched request during ACCESS and are
    // zero at all other times, so they feed the memory directly.
    logic             mem_en_reg;
    logic             mem_we_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;

    logic [31:0]      if_rdata_reg;
    logic [31:0]      d_rdata_reg;
    logic             if_ready_reg;
    logic             d_ready_reg;

    logic [1:0]       req;
    arb_grant_t       pick_grant;
    logic             pick_valid;

    assign req = {bus.d_read | bus.d_write, bus.if_req};

    arb_rr2 u_rr2 (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Arbitration FSM with access counter, request latches and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= GNT_IF;
            cnt_reg        <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_ready_reg   <= 1'b0;
            d_ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        last_grant_reg <= pick_grant;
                        cnt_reg        <= '0;
                        mem_en_reg     <= 1'b1;
                        if (pick_grant == GNT_D) begin
                            mem_we_reg    <= bus.d_write;
                            mem_addr_reg  <= bus.d_addr;
                            mem_wdata_reg <= bus.d_wdata;
                        end else begin
                            mem_we_reg    <= 1'b0;
                            mem_addr_reg  <= bus.if_addr;
                            mem_wdata_reg <= '0;
                        end
                        state_reg <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt_reg == CNT_LAST) begin
                        // Memory data is valid now; stores leave d_rdata untouched.
                        if (last_grant_reg == GNT_IF) begin
                            if_rdata_reg <= bus.mem_rdata;
                            if_ready_reg <= 1'b1;
                        end else begin
                            if (!mem_we_reg) begin
                                d_rdata_reg <= bus.mem_rdata;
                            end
                            d_ready_reg <= 1'b1;
                        end
                        mem_en_reg    <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        state_reg     <= ARB_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    if_ready_reg <= 1'b0;
                    d_ready_reg  <= 1'b0;
                    state_reg    <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.if_ready  = if_ready_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.d_ready   = d_ready_reg;

    // Hold the pipeline while a request is pending and not completing this cycle.
    assign bus.stall_pipe = (bus.if_req & ~if_ready_reg)
                          | ((bus.d_read | bus.d_write) & ~d_ready_reg);

endmodule
